parity_stream_unit: RTL and testbench
=====================================

Name: parity_stream_unit

Overview:
- Streaming, parametrised parity generator/checker for data of any width.
- Accepts beats on a valid/ready handshake and computes per-beat parity, with even or odd polarity set by parameter.
- In check mode, compares the computed parity against a received parity bit and counts mismatches in a saturating counter.
- Accumulates parity across multi-beat packets delimited by a last flag. Sits between a data source and a link/storage interface.

Parameters:
- DATA_W, 16: data beat width in bits, ≥1.
- ODD, 0: 0 = even parity (parity bit makes total ones even); 1 = odd parity.
- CNT_W, 8: width of the error counter, ≥1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = generate, 1 = check; sampled with each accepted beat.
- err_clr  input  1  synchronous clear of err_count.
- in_valid  input  1  input beat valid.
- in_ready  output  1  unit can accept a beat.
- in_data  input  DATA_W  beat data.
- in_par  input  1  received parity bit; used only in check mode.
- in_last  input  1  final beat of a packet.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the output beat.
- out_data  output  DATA_W  registered copy of in_data.
- out_par  output  1  computed beat parity.
- out_err  output  1  check-mode mismatch on this beat; always 0 in generate mode.
- out_last  output  1  registered copy of in_last.
- out_pkt_par  output  1  packet parity; meaningful only when out_valid && out_last, otherwise 0.
- err_count  output  CNT_W  saturating count of mismatched beats.

Behaviour:
- Reset (async): out_valid=0, out_data=0, out_par=0, out_err=0, out_last=0, out_pkt_par=0, err_count=0, packet accumulator acc=0.
- Handshake rules:
  - Input accept = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational, single register stage, no skid buffer).
- Latency and throughput: one cycle from accept to out_valid; full throughput of one beat per clock under continuous out_ready.
- On accept:
  - beat_raw = XOR reduction of in_data.
  - out_par <= beat_raw ^ ODD.
  - out_err <= mode & ((beat_raw ^ ODD) != in_par).
  - out_data, out_last are registered; out_valid <= 1.
- Output transfer without a simultaneous accept: out_valid <= 0. Data outputs hold their values.
- Backpressure: while out_valid && !out_ready, all out_* signals are held stable and no input is accepted.
- Packet accumulation (acc is the running XOR of beat_raw):
  - On accept with in_last=0: acc <= acc ^ beat_raw; out_pkt_par <= 0.
  - On accept with in_last=1: out_pkt_par <= acc ^ beat_raw ^ ODD; acc <= 0.
  - A single-beat packet (in_last=1 on the first beat) gives out_pkt_par = out_par.
- err_count:
  - Evaluated on accept of a beat with mode=1 and a parity mismatch.
  - Saturates at 2^CNT_W−1 with no wrap.
  - err_clr in the same cycle as a counted error: the result is 1 (clear, then count).
  - err_clr alone: the result is 0.
- mode may change between beats; each beat uses the mode value present at its accept. The packet accumulator is unaffected by mode.
- Reset mid-packet: acc and all outputs return to reset values; the next accepted beat starts a new packet.
- DATA_W=1: beat_raw = in_data[0].

Test Plan:
- DATA_W=16, ODD=0, generate; beats 0x0001, 0xFFFF, 0x0000, each with in_last=1, out_ready=1 -> out_par = 1, 0, 0 on consecutive cycles, each 1 cycle after accept; out_err=0; err_count=0.
- ODD=1 instance; beat 0x0003, in_last=1 -> out_par=1, out_pkt_par=1.
- Check mode, ODD=0: 0x0007 with in_par=0 -> out_err=1, err_count=1. Then 0x0007 with in_par=1 -> out_err=0, err_count stays 1. Then assert err_clr together with a mismatched beat -> err_count=1.
- Packet 0x0001, 0x0003, 0x0001 (last on the third beat), ODD=0 -> out_pkt_par=0 on the third output beat, 0 on the first two. Follow with a single-beat packet 0x0001 -> out_pkt_par=1, confirming acc was cleared.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* stable for those cycles; release -> beats delivered in order with no loss or duplication.
- CNT_W=2: 5 mismatched beats -> err_count = 1, 2, 3, 3, 3. Assert rst mid-packet after 2 beats -> all outputs 0; a subsequent 1-beat packet 0x0001 -> out_pkt_par=1.

Source files
------------

// File: rtl/parity_stream_unit.sv
// Streaming parity generator/checker: one register stage with valid/ready,
// per-beat and per-packet parity, and a saturating mismatch counter.
module parity_stream_unit #(
  parameter int DATA_W = 16,
  parameter int ODD    = 0,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              err_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par,
  output logic              out_err,
  output logic              out_last,
  output logic              out_pkt_par,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic ODD_B = (ODD != 0);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic              accept;
  logic              beat_raw_p0;
  logic              par_p0;
  logic              mism_p0;
  logic [CNT_W-1:0]  err_cnt_next;

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic              par_p1;
  logic              err_p1;
  logic              last_p1;
  logic              pkt_par_p1;
  logic              acc_p1;
  logic [CNT_W-1:0]  err_cnt_p1;

  // Stage p0: combinational parity of the incoming beat
  assign in_ready    = !vld_p1 || out_ready;
  assign accept      = in_valid && in_ready;
  assign beat_raw_p0 = ^in_data;
  assign par_p0      = beat_raw_p0 ^ ODD_B;
  assign mism_p0     = mode && (par_p0 != in_par);

  // Clear takes effect first so a same-cycle error still counts as one
  always_comb begin
    err_cnt_next = err_clr ? '0 : err_cnt_p1;
    if (accept && mism_p0) begin
      err_cnt_next = sat_inc(err_cnt_next);
    end
  end

  // Stage p1: registered output beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      data_p1    <= '0;
      par_p1     <= 1'b0;
      err_p1     <= 1'b0;
      last_p1    <= 1'b0;
      pkt_par_p1 <= 1'b0;
      acc_p1     <= 1'b0;
      err_cnt_p1 <= '0;
    end else begin
      if (accept) begin
        vld_p1  <= 1'b1;
        data_p1 <= in_data;
        par_p1  <= par_p0;
        err_p1  <= mism_p0;
        last_p1 <= in_last;
        if (in_last) begin
          pkt_par_p1 <= acc_p1 ^ par_p0;
          acc_p1     <= 1'b0;
        end else begin
          pkt_par_p1 <= 1'b0;
          acc_p1     <= acc_p1 ^ beat_raw_p0;
        end
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
      err_cnt_p1 <= err_cnt_next;
    end
  end

  assign out_valid   = vld_p1;
  assign out_data    = data_p1;
  assign out_par     = par_p1;
  assign out_err     = err_p1;
  assign out_last    = last_p1;
  // Packet parity is only exposed on a valid last beat
  assign out_pkt_par = pkt_par_p1 & vld_p1 & last_p1;
  assign err_count   = err_cnt_p1;

endmodule

// File: tb/tb_parity_stream_unit.sv
// Bench for parity_stream_unit: instance 0 is even parity / 8-bit counter,
// instance 1 is odd parity / 2-bit counter; a ones-counting model checks every cycle.
module tb_parity_stream_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode      [2];
  logic        err_clr   [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [15:0] in_data   [2];
  logic        in_par    [2];
  logic        in_last   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] out_data  [2];
  logic        out_par   [2];
  logic        out_err   [2];
  logic        out_last  [2];
  logic        out_pkt   [2];
  logic [7:0]  err_count0;
  logic [1:0]  err_count1;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  parity_stream_unit #(.DATA_W(16), .ODD(0), .CNT_W(8)) u_even (
    .clk(clk), .rst(rst), .mode(mode[0]), .err_clr(err_clr[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .in_par(in_par[0]), .in_last(in_last[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .out_par(out_par[0]),
    .out_err(out_err[0]), .out_last(out_last[0]), .out_pkt_par(out_pkt[0]),
    .err_count(err_count0)
  );

  parity_stream_unit #(.DATA_W(16), .ODD(1), .CNT_W(2)) u_odd (
    .clk(clk), .rst(rst), .mode(mode[1]), .err_clr(err_clr[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .in_par(in_par[1]), .in_last(in_last[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .out_par(out_par[1]),
    .out_err(out_err[1]), .out_last(out_last[1]), .out_pkt_par(out_pkt[1]),
    .err_count(err_count1)
  );

  task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, inst, act, exp);
    end
  endtask

  function automatic int odd_of(input int i);
    return (i == 1) ? 1 : 0;
  endfunction

  function automatic int cmax_of(input int i);
    return (i == 1) ? 3 : 255;
  endfunction

  // Parity as "count of ones plus polarity, modulo two"
  function automatic logic par_of(input logic [15:0] d, input int odd);
    return (($countones(d) + odd) % 2) == 1;
  endfunction

  function automatic logic [31:0] cnt_of(input int i);
    return (i == 0) ? 32'(err_count0) : 32'(err_count1);
  endfunction

  // Model state: what the output stage must show
  logic        m_valid [2];
  logic [15:0] m_data  [2];
  logic        m_par   [2];
  logic        m_err   [2];
  logic        m_last  [2];
  logic        m_pkt   [2];
  int          m_cnt   [2];
  int          m_ones  [2];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_valid[i] <= 1'b0; m_data[i] <= '0; m_par[i] <= 1'b0; m_err[i] <= 1'b0;
        m_last[i]  <= 1'b0; m_pkt[i]  <= 1'b0; m_cnt[i] <= 0;  m_ones[i] <= 0;
      end else if (in_valid[i] && (!m_valid[i] || out_ready[i])) begin
        m_valid[i] <= 1'b1;
        m_data[i]  <= in_data[i];
        m_par[i]   <= par_of(in_data[i], odd_of(i));
        m_err[i]   <= mode[i] && (par_of(in_data[i], odd_of(i)) != in_par[i]);
        m_last[i]  <= in_last[i];
        m_pkt[i]   <= in_last[i] ? (((m_ones[i] + $countones(in_data[i]) + odd_of(i)) % 2) == 1) : 1'b0;
        m_ones[i]  <= in_last[i] ? 0 : m_ones[i] + $countones(in_data[i]);
        if (mode[i] && (par_of(in_data[i], odd_of(i)) != in_par[i]))
          m_cnt[i] <= err_clr[i] ? 1 : ((m_cnt[i] < cmax_of(i)) ? m_cnt[i] + 1 : m_cnt[i]);
        else if (err_clr[i])
          m_cnt[i] <= 0;
      end else begin
        if (out_ready[i]) m_valid[i] <= 1'b0;
        if (err_clr[i]) m_cnt[i] <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check("in_ready", i, 32'(in_ready[i]), 32'(!m_valid[i] || out_ready[i]));
        check("out_valid", i, 32'(out_valid[i]), 32'(m_valid[i]));
        check("out_data", i, 32'(out_data[i]), 32'(m_data[i]));
        check("out_par", i, 32'(out_par[i]), 32'(m_par[i]));
        check("out_err", i, 32'(out_err[i]), 32'(m_err[i]));
        check("out_last", i, 32'(out_last[i]), 32'(m_last[i]));
        check("out_pkt_par", i, 32'(out_pkt[i]), 32'(m_valid[i] && m_last[i] && m_pkt[i]));
        check("err_count", i, cnt_of(i), 32'(m_cnt[i]));
      end
    end
  end

  // Drive one beat; returns 2 time units after the accepting edge
  task automatic send(input int i, input logic [15:0] d, input logic p, input logic l, input logic m);
    in_valid[i] = 1'b1; in_data[i] = d; in_par[i] = p; in_last[i] = l; mode[i] = m;
    @(posedge clk); #2;
    in_valid[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mode[i] = 1'b0; err_clr[i] = 1'b0; in_valid[i] = 1'b0; in_data[i] = '0;
      in_par[i] = 1'b0; in_last[i] = 1'b0; out_ready[i] = 1'b1;
    end
    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    check("rst_valid", 0, 32'(out_valid[0]), 32'd0);
    check("rst_data", 0, 32'(out_data[0]), 32'd0);
    check("rst_count", 1, 32'(err_count1), 32'd0);

    // Generate mode, back-to-back single-beat packets
    send(0, 16'h0001, 1'b0, 1'b1, 1'b0);
    check("gen_par_a", 0, 32'(out_par[0]), 32'd1);
    check("gen_valid_a", 0, 32'(out_valid[0]), 32'd1);
    send(0, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    check("gen_par_b", 0, 32'(out_par[0]), 32'd0);
    send(0, 16'h0000, 1'b0, 1'b1, 1'b0);
    check("gen_par_c", 0, 32'(out_par[0]), 32'd0);
    check("gen_err", 0, 32'(out_err[0]), 32'd0);
    check("gen_count", 0, 32'(err_count0), 32'd0);

    // Odd polarity
    send(1, 16'h0003, 1'b0, 1'b1, 1'b0);
    check("odd_par", 1, 32'(out_par[1]), 32'd1);
    check("odd_pkt", 1, 32'(out_pkt[1]), 32'd1);

    // Check mode and clear interplay
    send(0, 16'h0007, 1'b0, 1'b1, 1'b1);
    check("chk_err_a", 0, 32'(out_err[0]), 32'd1);
    check("chk_cnt_a", 0, 32'(err_count0), 32'd1);
    send(0, 16'h0007, 1'b1, 1'b1, 1'b1);
    check("chk_err_b", 0, 32'(out_err[0]), 32'd0);
    check("chk_cnt_b", 0, 32'(err_count0), 32'd1);
    err_clr[0] = 1'b1;
    send(0, 16'h0007, 1'b0, 1'b1, 1'b1);
    err_clr[0] = 1'b0;
    check("clr_and_err", 0, 32'(err_count0), 32'd1);
    err_clr[0] = 1'b1;
    @(posedge clk); #2;
    err_clr[0] = 1'b0;
    check("clr_alone", 0, 32'(err_count0), 32'd0);

    // Multi-beat packet then single-beat packet
    send(0, 16'h0001, 1'b0, 1'b0, 1'b0);
    check("pkt_b1", 0, 32'(out_pkt[0]), 32'd0);
    send(0, 16'h0003, 1'b0, 1'b0, 1'b0);
    check("pkt_b2", 0, 32'(out_pkt[0]), 32'd0);
    send(0, 16'h0001, 1'b0, 1'b1, 1'b0);
    check("pkt_b3", 0, 32'(out_pkt[0]), 32'd0);
    check("pkt_b3_last", 0, 32'(out_last[0]), 32'd1);
    send(0, 16'h0001, 1'b0, 1'b1, 1'b0);
    check("pkt_single", 0, 32'(out_pkt[0]), 32'd1);

    // Backpressure: first beat stalls in the output register while the second waits
    @(posedge clk); #2;
    out_ready[0] = 1'b0;
    send(0, 16'h1234, 1'b0, 1'b1, 1'b0);
    in_valid[0] = 1'b1; in_data[0] = 16'h00F0; in_last[0] = 1'b1;
    repeat (3) begin
      @(posedge clk); #2;
      check("bp_ready", 0, 32'(in_ready[0]), 32'd0);
      check("bp_data", 0, 32'(out_data[0]), 32'h1234);
      check("bp_par", 0, 32'(out_par[0]), 32'd1);
      check("bp_valid", 0, 32'(out_valid[0]), 32'd1);
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #2;
    in_valid[0] = 1'b0;
    check("bp_next_data", 0, 32'(out_data[0]), 32'h00F0);
    check("bp_next_valid", 0, 32'(out_valid[0]), 32'd1);
    @(posedge clk); #2;
    check("bp_drained", 0, 32'(out_valid[0]), 32'd0);

    // Saturation of a 2-bit counter with odd parity
    for (int k = 0; k < 5; k++) begin
      send(1, 16'h0001, 1'b1, 1'b1, 1'b1);
      check("sat_err", 1, 32'(out_err[1]), 32'd1);
      check("sat_cnt", 1, 32'(err_count1), (k < 3) ? 32'(k + 1) : 32'd3);
    end

    // Reset in the middle of a packet
    send(0, 16'h0001, 1'b0, 1'b0, 1'b0);
    send(0, 16'h0003, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 0, 32'(out_valid[0]), 32'd0);
    check("mid_rst_data", 0, 32'(out_data[0]), 32'd0);
    check("mid_rst_cnt", 1, 32'(err_count1), 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    send(0, 16'h0001, 1'b0, 1'b1, 1'b0);
    check("post_rst_pkt", 0, 32'(out_pkt[0]), 32'd1);
    check("post_rst_par", 0, 32'(out_par[0]), 32'd1);

    repeat (3) @(posedge clk);
    #6;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
